// File: rtl/noc_switch_allocator.sv
// noc_switch_allocator
//   Per-output wormhole switch allocator for a 5-port NoC router
//   (port codes 0=N, 1=S, 2=E, 3=W, 4=L). Each output runs an IDLE/LOCKED
//   FSM. In IDLE it arbitrates round-robin among legal requesters. In LOCKED
//   it forwards its owner's flits until a tail flit transfers. Arbitration
//   looks only at registered state, so a lock always costs one cycle before
//   the first flit moves.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   req_i[i]         input i presents a valid flit
//   dest_i[3i+2:3i]  destination output code of input i
//   tail_i[i]        input i's flit is the last of its packet
//   out_ready_i[o]   downstream of output o can accept a flit
//   grant_o[i]       input i's flit crosses the switch this cycle
//   *_port_select    crossbar select per output (owner, or IDLE_SEL)
//   out_valid_o[o]   output o carries a valid flit this cycle
//   err_o            registered pulse: U-turn or out-of-range request last cycle
module noc_switch_allocator #(
    parameter int unsigned NPORTS   = 5,
    parameter logic [2:0]  IDLE_SEL = 3'b111
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORTS-1:0]     req_i,
    input  logic [3*NPORTS-1:0]   dest_i,
    input  logic [NPORTS-1:0]     tail_i,
    input  logic [NPORTS-1:0]     out_ready_i,
    output logic [NPORTS-1:0]     grant_o,
    output logic [2:0]            N_port_select,
    output logic [2:0]            S_port_select,
    output logic [2:0]            E_port_select,
    output logic [2:0]            W_port_select,
    output logic [2:0]            L_port_select,
    output logic [NPORTS-1:0]     out_valid_o,
    output logic                  err_o
);

    localparam logic [2:0] LAST = 3'(NPORTS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e      state_q [NPORTS];
    logic [2:0]  owner_q [NPORTS];
    logic [2:0]  rr_q    [NPORTS];
    logic        err_q;

    logic [2:0]        dest   [NPORTS];
    logic [NPORTS-1:0] legal  [NPORTS];
    logic [2:0]        pick_d [NPORTS];
    logic [2:0]        sel    [NPORTS];
    logic [NPORTS-1:0] busy;
    logic [NPORTS-1:0] found_d;
    logic [NPORTS-1:0] xfer;
    logic [NPORTS-1:0] rel_d;
    logic              err_d;

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        assign dest[g] = dest_i[3*g +: 3];
        assign sel[g]  = (state_q[g] == LOCKED) ? owner_q[g] : IDLE_SEL;
    end

    // An input that owns a locked output is committed to it; its dest is
    // ignored and it may not compete for (or flag errors on) anything else.
    always_comb begin
        busy = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                if (state_q[o] == LOCKED && owner_q[o] == 3'(i)) begin
                    busy[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        int unsigned idx;
        idx   = 0;
        err_d = 1'b0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (req_i[i] && !busy[i] && (dest[i] == 3'(i) || dest[i] > LAST)) begin
                err_d = 1'b1;
            end
        end
        for (int unsigned o = 0; o < NPORTS; o++) begin
            legal[o]   = '0;
            found_d[o] = 1'b0;
            pick_d[o]  = '0;
            for (int unsigned i = 0; i < NPORTS; i++) begin
                legal[o][i] = req_i[i] && !busy[i] && (dest[i] == 3'(o)) && (i != o);
            end
            // Round-robin scan starting at rr; first legal hit wins.
            for (int unsigned k = 0; k < NPORTS; k++) begin
                idx = (32'(rr_q[o]) + k) % NPORTS;
                for (int unsigned i = 0; i < NPORTS; i++) begin
                    if (i == idx && !found_d[o] && legal[o][i]) begin
                        found_d[o] = 1'b1;
                        pick_d[o]  = 3'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        xfer    = '0;
        rel_d   = '0;
        grant_o = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                if (state_q[o] == LOCKED && owner_q[o] == 3'(i) &&
                    req_i[i] && out_ready_i[o]) begin
                    xfer[o]    = 1'b1;
                    grant_o[i] = 1'b1;
                    rel_d[o]   = tail_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned o = 0; o < NPORTS; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                rr_q[o]    <= '0;
            end
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
            for (int unsigned o = 0; o < NPORTS; o++) begin
                case (state_q[o])
                    IDLE: begin
                        if (found_d[o]) begin
                            state_q[o] <= LOCKED;
                            owner_q[o] <= pick_d[o];
                        end
                    end
                    LOCKED: begin
                        if (rel_d[o]) begin
                            state_q[o] <= IDLE;
                            rr_q[o]    <= (owner_q[o] == LAST) ? '0 : owner_q[o] + 3'd1;
                        end
                    end
                    default: state_q[o] <= IDLE;
                endcase
            end
        end
    end

    assign out_valid_o   = xfer;
    assign err_o         = err_q;
    assign N_port_select = sel[0];
    assign S_port_select = sel[1];
    assign E_port_select = sel[2];
    assign W_port_select = sel[3];
    assign L_port_select = sel[4];

endmodule
